mmio_display_bridge: RTL and testbench
======================================

Name: mmio_display_bridge

Overview:
- Memory-mapped responder on the ARM core's data bus (address / write_data / mem_write / read_data), decoded in parallel with the data memory.
- CPU writes display words into an internal FIFO through a register window.
- A display-side consumer (VGA stage) drains the FIFO over a valid/ready handshake.
- The top level muxes read_data from this block or from data memory using sel.

Parameters:
- BASE_ADDR, 32'h0000_1000: window base. Window is 16 bytes; BASE_ADDR[3:0] must be 0.
- DEPTH, 8: FIFO entries. Power of two, range 2..128.
- WIDTH, 32: data word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- address  in  32  CPU byte address (ALU result).
- write_data  in  WIDTH  CPU store data.
- mem_write  in  1  CPU store strobe, sampled at the clk rising edge.
- read_data  out  WIDTH  register read data, combinational.
- sel  out  1  high when address falls inside the window.
- out_valid  out  1  head word available to the consumer.
- out_data  out  WIDTH  FIFO head word (fall-through).
- out_ready  in  1  consumer accepts the head word.
- fifo_full  out  1  mirror of STATUS.full.

Behaviour:
- Decode
  - sel = (address[31:4] == BASE_ADDR[31:4]).
  - offset = address[3:2].
  - address[1:0] is ignored.
- Register map
  - 0x0 STATUS (RO): bit0 full, bit1 empty, bit2 enable, bits[15:8] count, other bits 0.
  - 0x4 DATA (WO): a store pushes write_data. Reads return 0.
  - 0x8 CTRL (RW): bit0 enable (R/W). bit1 flush is write-only, self-clearing, and reads 0.
  - 0xC DROPS (RW): bits[15:0] saturating count of pushes rejected because the FIFO was full. Any store to 0xC clears it to 0.
- Reads: read_data is combinational from current state. When sel=0, read_data=0.
- Writes: take effect at the rising edge when mem_write && sel. Stores outside the window are ignored.
- Push
  - A DATA store with count<DEPTH writes the tail entry and increments count.
  - A DATA store with count==DEPTH changes no FIFO state and increments DROPS, saturating at 16'hFFFF.
- Pop
  - out_valid = enable && (count != 0).
  - out_data = head entry. It is valid only while out_valid=1 and is held stable until popped.
  - Pop occurs when out_valid && out_ready at the edge.
- Simultaneous push and pop
  - Both happen; count is unchanged.
  - When full, the pop frees a slot and the same-cycle push is accepted. No drop is recorded.
  - When empty, out_valid=0, so only the push happens.
- Flush: a CTRL store with bit1=1 sets count, head and tail to 0 at that edge. It overrides any same-cycle pop. bit0 is still written from the same store.
- enable=0: the FIFO still accepts pushes; out_valid is held at 0.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count is log2(DEPTH)+1 bits, zero-extended into STATUS[15:8].
- Reset (async assert, sync release): count=0, head=tail=0, enable=0, DROPS=0. Resulting outputs: out_valid=0, fifo_full=0, STATUS reads 32'h0000_0002. FIFO storage is not reset.
- Reset mid-operation: all queued words are discarded. The consumer must treat out_valid falling as abandonment.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants: OFF_STATUS, OFF_DATA, OFF_CTRL, OFF_DROPS;
  - STATUS/CTRL bit-position constants;
  - the default BASE_ADDR constant.
- One sub-module, sync_fifo (parameters DEPTH, WIDTH):
  - inputs push, pop, flush, din;
  - outputs dout, count, full, empty.
- The bridge itself contains decode, the register file and the drop counter.

Test Plan:
- Reset → STATUS=32'h0000_0002, out_valid=0, DROPS=0. Read at BASE_ADDR+0x20 → read_data=0, sel=0.
- CTRL=1, then DATA stores 0xA1, 0xA2, 0xA3 with out_ready=0 → count=3, out_data=0xA1. Raise out_ready for 3 cycles → words pop in order 0xA1, 0xA2, 0xA3, then out_valid=0 and STATUS.empty=1.
- enable=0, 10 DATA stores 0x10..0x19 → FIFO holds 0x10..0x17, full=1, DROPS=2, out_valid=0. Then CTRL=1 → out_valid=1, out_data=0x10.
- Full FIFO, out_ready=1, DATA store 0x55 in the same cycle → count stays 8, DROPS unchanged, 0x55 emerges as the 8th pop after 0x11..0x17.
- 4 words queued, CTRL=3 written while out_ready=1 → count=0 next cycle, no pop observed, enable stays 1. Store 0 to 0xC → DROPS=0.
- 5 words queued, reset pulsed low mid-stream → out_valid=0 asynchronously, STATUS=32'h0000_0002 after release. Pointers wrap correctly across 3×DEPTH push/pop cycles with incrementing data.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register map and bit positions for the display bridge
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

    // Word offsets (address[3:2]) inside the 16-byte window
    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_DATA   = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_DROPS  = 2'd3;

    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_ENABLE_BIT = 2;
    localparam int STATUS_COUNT_LSB  = 8;
    localparam int STATUS_COUNT_W    = 8;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    localparam int DROPS_WIDTH = 16;

endpackage

// File: rtl/mmio_display_bridge_if.sv
// rtl/mmio_display_bridge_if.sv - CPU data-bus window plus display drain handshake
interface mmio_display_bridge_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      address;
    logic [WIDTH-1:0] write_data;
    logic             mem_write;
    logic [WIDTH-1:0] read_data;
    logic             sel;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             fifo_full;

    modport master (
        output address, write_data, mem_write, out_ready,
        input  read_data, sel, out_valid, out_data, fifo_full
    );

    modport slave (
        input  address, write_data, mem_write, out_ready,
        output read_data, sel, out_valid, out_data, fifo_full
    );
endinterface

// File: rtl/mmio_display_bridge_sync_fifo.sv
// rtl/mmio_display_bridge_sync_fifo.sv - fall-through FIFO with flush, push accepted on full when popping
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE   = 1;
    localparam logic [PW:0]   CNT_DEPTH = DEPTH[PW:0];
    localparam logic [PW-1:0] PTR_ONE   = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push on a full FIFO needs
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_ONE;
            if (do_pop)  head <= head + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail] <= din;
    end

endmodule

// File: rtl/mmio_display_bridge.sv
// rtl/mmio_display_bridge.sv - memory-mapped display FIFO window with status, control and drop counter
module mmio_display_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 8,
    parameter int          WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_display_bridge_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DROPS_WIDTH-1:0] DROPS_ONE = 1;

    logic [1:0]             offset;
    logic                   wr_en;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   drop;
    logic                   enable;
    logic [DROPS_WIDTH-1:0] drops;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   empty;
    logic [31:0]            reg_rdata;
    logic                   unused_addr_lsbs;

    assign bus.sel          = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign offset           = bus.address[3:2];
    assign unused_addr_lsbs = ^bus.address[1:0];
    assign wr_en            = bus.mem_write && bus.sel;

    assign push  = wr_en && (offset == OFF_DATA);
    assign flush = wr_en && (offset == OFF_CTRL) && bus.write_data[CTRL_FLUSH_BIT];

    assign bus.out_valid = enable && !empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.fifo_full = full;
    // Only a push that finds no slot, even counting a same-cycle pop, is a drop
    assign drop          = push && full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.write_data),
        .dout  (bus.out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
        end else if (wr_en && (offset == OFF_CTRL)) begin
            enable <= bus.write_data[CTRL_ENABLE_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops <= '0;
        end else if (wr_en && (offset == OFF_DROPS)) begin
            drops <= '0;
        end else if (drop && (drops != '1)) begin
            drops <= drops + DROPS_ONE;
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (bus.sel) begin
            case (offset)
                OFF_STATUS: begin
                    reg_rdata[STATUS_FULL_BIT]   = full;
                    reg_rdata[STATUS_EMPTY_BIT]  = empty;
                    reg_rdata[STATUS_ENABLE_BIT] = enable;
                    reg_rdata[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(count);
                end
                OFF_CTRL:  reg_rdata[CTRL_ENABLE_BIT]   = enable;
                OFF_DROPS: reg_rdata[DROPS_WIDTH-1:0]   = drops;
                default:   reg_rdata = '0;
            endcase
        end
    end

    assign bus.read_data = WIDTH'(reg_rdata);

endmodule

// File: tb/tb_mmio_display_bridge.sv
// tb/tb_mmio_display_bridge.sv - directed and random checks of the display bridge against a queue model
module tb_mmio_display_bridge;
    import mmio_pkg::*;

    localparam logic [31:0] BASE  = DEFAULT_BASE_ADDR;
    localparam int          DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_display_bridge_if #(.WIDTH(32)) bus ();

    mmio_display_bridge #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .WIDTH     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        m_en;
    logic [15:0] m_drops;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(logic [31:0] a);
        logic [31:0] v;
        int n;
        n = q.size();
        v = '0;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: begin
                    v[15:8] = 8'(n);
                    v[2]    = m_en;
                    v[1]    = (n == 0);
                    v[0]    = (n == DEPTH);
                end
                2'd2: v[0] = m_en;
                2'd3: v[15:0] = m_drops;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en    = 1'b0;
        m_drops = '0;
    endtask

    task automatic check_outputs(logic [31:0] a);
        chk("sel", 32'(bus.sel), 32'(a[31:4] == BASE[31:4]));
        chk("read_data", bus.read_data, exp_read(a));
        chk("out_valid", 32'(bus.out_valid), 32'(m_en && q.size() != 0));
        chk("fifo_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
        if (m_en && q.size() != 0) chk("out_data", bus.out_data, q[0]);
    endtask

    // One bus cycle: drive at negedge, check, then advance the model at the edge
    task automatic step(logic [31:0] a, logic [31:0] d, logic w, logic r);
        logic       wr, do_pop, was_full;
        logic [1:0] off;
        @(negedge clk);
        bus.address    = a;
        bus.write_data = d;
        bus.mem_write  = w;
        bus.out_ready  = r;
        #1;
        check_outputs(a);
        wr       = w && (a[31:4] == BASE[31:4]);
        off      = a[3:2];
        do_pop   = m_en && (q.size() != 0) && r;
        was_full = (q.size() == DEPTH);
        @(posedge clk);
        if (wr && off == 2'd2) begin
            m_en = d[0];
            if (d[1]) begin
                q.delete();
                do_pop = 1'b0;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (wr && off == 2'd1) begin
            if (!was_full || do_pop) q.push_back(d);
            else if (m_drops != 16'hFFFF) m_drops++;
        end
        if (wr && off == 2'd3) m_drops = '0;
        #1;
    endtask

    initial begin
        logic [31:0] exp_drain [8];
        logic [31:0] a, d;
        logic [1:0]  off;

        bus.address    = '0;
        bus.write_data = '0;
        bus.mem_write  = 1'b0;
        bus.out_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state and out-of-window read
        step(BASE, 0, 0, 0);
        chk("reset_status", bus.read_data, 32'h0000_0002);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        step(BASE + 32'hC, 0, 0, 0);
        chk("reset_drops", bus.read_data, 32'd0);
        step(BASE + 32'h20, 0, 0, 0);
        chk("outside_sel", 32'(bus.sel), 32'd0);
        chk("outside_rd", bus.read_data, 32'd0);

        // Three words, then drained in order
        step(BASE + 32'h8, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(BASE + 32'h4, 32'hA1 + i, 1, 0);
        step(BASE, 0, 0, 0);
        chk("three_status", bus.read_data, 32'h0000_0304);
        chk("three_head", bus.out_data, 32'hA1);
        for (int i = 0; i < 3; i++) step(BASE, 0, 0, 1);
        step(BASE, 0, 0, 0);
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_status", bus.read_data, 32'h0000_0006);

        // Disabled fill past full
        step(BASE + 32'h8, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(BASE + 32'h5, 32'h10 + i, 1, 0);
        step(BASE + 32'hC, 0, 0, 0);
        chk("drops_two", bus.read_data, 32'd2);
        chk("full_flag", 32'(bus.fifo_full), 32'd1);
        chk("disabled_valid", 32'(bus.out_valid), 32'd0);
        step(BASE + 32'h8, 1, 1, 0);
        chk("enabled_valid", 32'(bus.out_valid), 32'd1);
        chk("enabled_head", bus.out_data, 32'h10);

        // Push and pop together on full
        step(BASE + 32'h4, 32'h55, 1, 1);
        step(BASE, 0, 0, 0);
        chk("fullpp_status", bus.read_data, 32'h0000_0805);
        step(BASE + 32'hC, 0, 0, 0);
        chk("fullpp_drops", bus.read_data, 32'd2);
        for (int i = 0; i < 7; i++) exp_drain[i] = 32'h11 + i;
        exp_drain[7] = 32'h55;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", bus.out_data, exp_drain[i]);
            step(BASE, 0, 0, 1);
        end

        // Flush while the consumer is ready
        for (int i = 0; i < 4; i++) step(BASE + 32'h4, 32'h60 + i, 1, 0);
        step(BASE + 32'h8, 3, 1, 1);
        step(BASE, 0, 0, 0);
        chk("flush_status", bus.read_data, 32'h0000_0006);
        step(BASE + 32'hC, 0, 1, 0);
        step(BASE + 32'hC, 0, 0, 0);
        chk("drops_cleared", bus.read_data, 32'd0);

        // Reset while words are queued
        for (int i = 0; i < 5; i++) step(BASE + 32'h4, 32'h70 + i, 1, 0);
        @(negedge clk);
        bus.mem_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(BASE, 0, 0, 0);
        chk("post_reset_status", bus.read_data, 32'h0000_0002);

        // Pointer wrap across three full laps
        step(BASE + 32'h8, 1, 1, 0);
        for (int i = 0; i < 3 * DEPTH; i++) step(BASE + 32'h4, 32'h100 + i, 1, 1);
        step(BASE, 0, 0, 1);
        step(BASE, 0, 0, 0);
        chk("wrap_empty", bus.read_data, 32'h0000_0006);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) off = 2'd1;
            a = BASE + {28'd0, off, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) a = BASE + 32'd16 * $urandom_range(1, 50);
            d = $urandom;
            if (off == 2'd2) begin
                d[1] = ($urandom_range(0, 9) == 0);
                d[0] = ($urandom_range(0, 4) != 0);
            end
            step(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
